// File: rtl/sad_pkg.sv
// sad_pkg: shared FSM encoding, default sizes and result-width derivation for sad_accum
package sad_pkg;
    localparam int DEF_DIFF_WIDTH = 9;
    localparam int DEF_BLOCK_LEN  = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Sum of BLOCK_LEN samples of dw bits never needs more than dw+log2(BLOCK_LEN) bits
    function automatic int sad_width(input int dw, input int bl);
        return dw + $clog2(bl);
    endfunction
endpackage

// File: rtl/sad_accum.sv
// sad_accum: accumulates BLOCK_LEN absolute differences and holds the block sum
// until the downstream consumer takes it.
module sad_accum
    import sad_pkg::*;
#(
    parameter int DIFF_WIDTH = DEF_DIFF_WIDTH,
    parameter int BLOCK_LEN  = DEF_BLOCK_LEN,
    parameter int SAD_WIDTH  = sad_width(DIFF_WIDTH, BLOCK_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DIFF_WIDTH-1:0] in_diff,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [SAD_WIDTH-1:0]  out_sad,
    input  logic                  out_ready
);
    localparam int CW = $clog2(BLOCK_LEN);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SAD_WIDTH-1:0] acc_q, acc_d;
    logic                 accept;
    logic                 last;

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == HOLD;
    assign out_sad   = out_valid ? acc_q : '0;
    assign accept    = in_valid && in_ready;
    assign last      = cnt_q == CW'(BLOCK_LEN - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (state_q == ACCUM) begin
            if (clr) begin
                cnt_d = '0;
                acc_d = '0;
            end else if (accept) begin
                // counter wraps to 0 on the final sample, ready for the next block
                acc_d   = (cnt_q == '0 ? '0 : acc_q) + SAD_WIDTH'(in_diff);
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? HOLD : ACCUM;
            end
        end else if (clr || out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_sad_accum.sv
// tb_sad_accum: randomized and directed stimulus for sad_accum, checked by a
// block-sum reference model feeding a scoreboard queue.
module tb_sad_accum;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_diff = '0;
    logic        in_ready;
    logic        out_valid;
    logic [12:0] out_sad;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int last_sad = -1;
    int n_results = 0;
    bit mon_en = 1'b0;

    // reference model state: samples seen in the open block, and whether a sum is pending
    bit m_hold = 1'b0;
    int m_cnt = 0;
    int m_sum = 0;

    sad_accum dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_diff  (in_diff),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_sad  (out_sad),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            if (m_hold) void'(exp_q.pop_front());
            m_hold = 1'b0;
            m_cnt  = 0;
            m_sum  = 0;
        end else if (m_hold) begin
            if (clr) void'(exp_q.pop_front());
            if (clr || out_ready) m_hold = 1'b0;
        end else if (clr) begin
            m_cnt = 0;
            m_sum = 0;
        end else if (in_valid) begin
            m_sum += int'(in_diff);
            m_cnt++;
            if (m_cnt == BL) begin
                exp_q.push_back(m_sum);
                m_hold = 1'b1;
                m_cnt  = 0;
                m_sum  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", int'(in_ready), int'(!m_hold));
            chk("out_valid", int'(out_valid), int'(m_hold));
            if (!out_valid) chk("out_sad_idle", int'(out_sad), 0);
            else if (exp_q.size() == 0) chk("result_unexpected", int'(out_sad), -1);
            else if (out_ready && !clr && !rst) begin
                last_sad = exp_q.pop_front();
                n_results++;
                chk("out_sad", int'(out_sad), last_sad);
            end else chk("out_sad_hold", int'(out_sad), exp_q[0]);
        end
    end

    task automatic step(input bit v, input int d, input bit ordy, input bit c, input bit r);
        in_valid  = v;
        in_diff   = 9'(d);
        out_ready = ordy;
        clr       = c;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic block(input int d, input int inc, input bit ordy);
        for (int i = 0; i < BL; i++) step(1'b1, d + i * inc, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int a, b;
        @(posedge clk);
        #1;
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_sad", int'(out_sad), 0);

        n0 = n_results;
        block(256, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("b2b_256", last_sad, 4096);

        block(511, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("max_511", last_sad, 8176);
        block(0, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("zeros", last_sad, 0);

        block(1, 1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 99, 1'b0, 1'b0, 1'b0);
        step(1'b1, 99, 1'b1, 1'b0, 1'b0);
        chk("stall_136", last_sad, 136);
        block(5, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("after_release", last_sad, 80);

        n0 = n_results;
        for (int i = 0; i < 7; i++) step(1'b1, 9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9, 1'b1, 1'b1, 1'b0);
        block(1, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("clr_result", last_sad, 16);
        chk("clr_count", n_results - n0, 1);

        n0 = n_results;
        block(1, 1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        chk("rst_hold_valid", int'(out_valid), 0);
        chk("rst_hold_ready", int'(in_ready), 1);
        block(2, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("rst_result", last_sad, 32);
        chk("rst_count", n_results - n0, 1);

        n0 = 0;
        while (n0 < BL) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 77, 1'b1, 1'b0, 1'b0);
            else begin
                step(1'b1, 3, 1'b1, 1'b0, 1'b0);
                n0++;
            end
        end
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("gaps_48", last_sad, 48);

        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 511));
            b = int'($urandom_range(0, 511));
            step($urandom_range(0, 3) != 0, a > b ? a - b : b - a,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0,
                 $urandom_range(0, 250) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sad_accum.md
SAD_ACCUM -- requirements
Module: sad_accum

Interface
REQ-001 SHALL have parameter DIFF_WIDTH, default 9, width of one absolute-difference sample (abs_diff res output).
REQ-002 SHALL have parameter BLOCK_LEN, default 16, samples per block; power of two, range 2..256.
REQ-003 SHALL have parameter SAD_WIDTH, default DIFF_WIDTH+log2(BLOCK_LEN) (13), result width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clr  input  1  abort the current block and discard its partial sum.
REQ-008 in_valid  input  1  in_diff holds a valid sample.
REQ-009 in_diff  input  DIFF_WIDTH  unsigned |a-b| sample from the abs_diff stage.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 out_valid  output  1  out_sad holds a completed block sum.
REQ-012 out_sad  output  SAD_WIDTH  sum of absolute differences of one block.
REQ-013 out_ready  input  1  downstream consumes out_sad this cycle.

Function
REQ-014 SHALL implement FSM states ACCUM and HOLD; reset state ACCUM.
REQ-015 in_ready SHALL be 1 exactly when state is ACCUM (decoded from state only, not from in_valid).
REQ-016 Accept SHALL mean in_valid && in_ready; no other cycle changes the accumulator or sample counter.
REQ-017 On accept with counter 0, acc SHALL load in_diff; otherwise acc SHALL load acc+in_diff; counter SHALL increment.
REQ-018 Arithmetic SHALL be unsigned, zero-extended to SAD_WIDTH; no overflow is possible, and no saturation logic is required.
REQ-019 On the BLOCK_LEN-th accept, the next cycle SHALL show out_valid=1 and out_sad=full block sum, state=HOLD, counter=0.
REQ-020 Latency from the final accepted sample to out_valid SHALL be exactly 1 cycle.
REQ-021 In HOLD, out_sad and out_valid SHALL remain stable until out_ready=1; in_valid is ignored.
REQ-022 On out_valid && out_ready, the next cycle SHALL show out_valid=0 and state=ACCUM; acceptance resumes that cycle.
REQ-023 Gaps in in_valid SHALL NOT affect the sum; the counter counts accepts, not cycles.
REQ-024 out_sad SHALL read 0 whenever out_valid=0.
REQ-025 clr in ACCUM SHALL zero the counter and accumulator next cycle; a sample accepted in the same cycle as clr is dropped (clr wins).
REQ-026 clr in HOLD SHALL drop out_valid next cycle, discard the result and return to ACCUM; clr has priority over out_ready.
REQ-027 rst SHALL have priority over clr and over all handshakes.

Reset
REQ-028 While rst=1 at a clock edge: state=ACCUM, counter=0, acc=0, out_valid=0, out_sad=0, in_ready=1 next cycle.
REQ-029 Reset mid-block or in HOLD SHALL discard all partial or pending results; no result for that block is ever emitted.

Structure
REQ-030 Shared package sad_pkg SHALL hold the FSM state encoding, the default DIFF_WIDTH/BLOCK_LEN and the SAD_WIDTH derivation.
REQ-031 No sub-module SHALL be required; counter, accumulator and FSM reside in sad_accum.
REQ-032 The block SHALL connect directly downstream of abs_diff (res -> in_diff) without glue logic.

Verification (defaults, BLOCK_LEN=16)
REQ-033 16 back-to-back samples of 256, out_ready=1 -> out_valid one cycle after the 16th sample, out_sad=4096, in_ready=0 for exactly 1 cycle.
REQ-034 16 samples of 511 -> out_sad=8176 with no wrap; next block of 16 zeros -> out_sad=0.
REQ-035 Block of values 1..16 with out_ready=0 for 5 cycles and in_valid held high -> out_sad=136 stable and in_ready=0 throughout; the first sample after release starts a new block.
REQ-036 7 samples of 9, then clr, then 16 samples of 1 -> single result with out_sad=16; no result for the aborted block.
REQ-037 rst asserted in HOLD (out_sad=136) -> out_valid=0 and in_ready=1 on the next cycle; the following 16 samples of 2 -> out_sad=32.
REQ-038 16 samples of 3 with random in_valid gaps -> out_sad=48; scoreboard compares against the sum of abs_diff outputs over 1000 seeded random pairs.
